// File: rtl/keycode_fifo_port.sv
// -----------------------------------------------------------------------------
// keycode_fifo_port
//
// Purpose:
//   Avalon-MM slave that queues keycodes written by the Nios II into a FIFO
//   and presents them to fabric logic through a valid/ready stream. This is the
//   buffered successor of the single-register keycode PIO: a consumer that
//   reads slower than keys are pushed no longer loses them (up to DEPTH keys).
//
// Parameters:
//   DATA_W  keycode width in bits (1..16)
//   DEPTH   FIFO entries, power of two (2..256)
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0] register select
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   readdata    out  [31:0] read data, combinational from address (0 when
//                    chipselect is low)
//   out_port    out  [DATA_W-1:0] FIFO head keycode, 0 when empty
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer accept
//   irq         out  interrupt request
//
// Register map (write strobe = chipselect & ~write_n):
//   0  W: push writedata[DATA_W-1:0]   R: head keycode zero-extended
//   1  R: [CNT_W-1:0] count, [16] empty, [17] full, [18] overflow (sticky)
//      W: bit0 = flush, bit1 = clear overflow (may be combined)
//   2  IRQ config: [CNT_W-1:0] threshold, [30] ovf_irq_en, [31] lvl_irq_en
//      (only with KEYCODE_FIFO_IRQ_EN, otherwise reads 0 / writes ignored)
//   3  reserved: reads 0, writes ignored
//
// Configuration macro:
//   KEYCODE_FIFO_IRQ_EN  enables the IRQ config register and registered irq.
//                        Undefined: irq is tied low, no config flops exist.
//
// Stream handshake:
//   A key transfers on every rising clk edge where out_valid & out_ready are
//   both high. out_valid/out_port depend only on registered state (count,
//   read pointer, array), never combinationally on out_ready. The producer
//   side may hold out_port/out_valid stable until the transfer occurs.
// -----------------------------------------------------------------------------
module keycode_fifo_port #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    // ------------------------------------------------------------------
    // Decode and next-state
    // ------------------------------------------------------------------
    logic              w_wr;
    logic              w_push_req;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_set;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_overflow_next;
    logic [31:0]       w_status;
    logic [31:0]       w_cfg_rdata;

    // Only the low DATA_W bits and a few control bits of writedata carry
    // meaning; fold the whole bus into one sink so no bit is left dangling.
    logic              w_unused_wdata;
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_wr       = chipselect & ~write_n;
        w_push_req = w_wr && (address == 2'd0);
        w_flush    = w_wr && (address == 2'd1) && writedata[0];
        w_clr_ovf  = w_wr && (address == 2'd1) && writedata[1];

        w_empty    = (r_count == '0);
        w_full     = (r_count == FULL_CNT);

        // Flush dominates everything on its edge: no pop, no push, and a
        // dropped push in that cycle is not counted as an overflow.
        w_pop      = !w_empty && out_ready && !w_flush;
        // A full FIFO still accepts a push when a pop frees a slot on the
        // same edge; only a push into a full FIFO without a pop is lost.
        w_push     = w_push_req && !w_flush && (!w_full || w_pop);
        w_ovf_set  = w_push_req && !w_flush && w_full && !w_pop;
    end

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CNT_W'(1);
                2'b01:   w_count_next = r_count - CNT_W'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Setting the sticky flag takes priority over a clear on the same edge.
    always_comb begin
        w_overflow_next = r_overflow;
        if (w_ovf_set) begin
            w_overflow_next = 1'b1;
        end else if (w_clr_ovf) begin
            w_overflow_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_overflow <= w_overflow_next;
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // Pointers are exactly log2(DEPTH) wide, so natural
                // overflow of the adder gives the modulo-DEPTH wrap.
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Key storage is deliberately not reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= writedata[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Stream outputs
    // ------------------------------------------------------------------
    assign out_valid = !w_empty;
    assign out_port  = w_empty ? '0 : r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // Optional interrupt logic
    // ------------------------------------------------------------------
`ifdef KEYCODE_FIFO_IRQ_EN
    logic [CNT_W-1:0] r_threshold;
    logic             r_ovf_irq_en;
    logic             r_lvl_irq_en;
    logic             r_irq;
    logic             w_cfg_wr;

    assign w_cfg_wr = w_wr && (address == 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_threshold  <= CNT_W'(1);
            r_ovf_irq_en <= 1'b0;
            r_lvl_irq_en <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_cfg_wr) begin
                r_threshold  <= writedata[CNT_W-1:0];
                r_ovf_irq_en <= writedata[30];
                r_lvl_irq_en <= writedata[31];
            end
            // Level interrupt computed from next-state values so it lines
            // up with the status the CPU reads after the same edge.
            r_irq <= (r_lvl_irq_en && (w_count_next >= r_threshold)) ||
                     (r_ovf_irq_en && w_overflow_next);
        end
    end

    assign irq = r_irq;

    always_comb begin
        w_cfg_rdata              = '0;
        w_cfg_rdata[CNT_W-1:0]   = r_threshold;
        w_cfg_rdata[30]          = r_ovf_irq_en;
        w_cfg_rdata[31]          = r_lvl_irq_en;
    end
`else
    assign irq         = 1'b0;
    assign w_cfg_rdata = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux (zero wait states, zero latency)
    // ------------------------------------------------------------------
    always_comb begin
        w_status              = '0;
        w_status[CNT_W-1:0]   = r_count;
        w_status[16]          = w_empty;
        w_status[17]          = w_full;
        w_status[18]          = r_overflow;
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata[DATA_W-1:0] = out_port;
                2'd1:    readdata = w_status;
                2'd2:    readdata = w_cfg_rdata;
                default: readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_keycode_fifo_port.sv
module tb_keycode_fifo_port;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  localparam logic [31:0] ST_EMPTY = 32'h0001_0000;
  localparam logic [31:0] ST_FULL  = 32'h0002_0000;
  localparam logic [31:0] ST_OVF   = 32'h0004_0000;

  // ---------------------------------------------------------------
  // clock / reset
  // ---------------------------------------------------------------
  logic              clk;
  logic              reset_n;
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_port;
  logic              out_valid;
  logic              out_ready;
  logic              irq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  keycode_fifo_port #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .irq        (irq)
  );

`ifdef KEYCODE_FIFO_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  // ---------------------------------------------------------------
  // scoreboard counters and checker
  // ---------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------
  // driver tasks (entered and left at posedge+1)
  // ---------------------------------------------------------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic rdy);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    out_ready  = rdy;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    out_ready  = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    out_ready = rdy;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_state(input string name, input logic exp_valid,
                             input logic [DATA_W-1:0] exp_port, input logic [31:0] exp_stat);
    logic [31:0] rd;
    check({name, ".valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
    check({name, ".port"}, {24'd0, out_port}, {24'd0, exp_port});
    bus_read(2'd1, rd);
    check({name, ".status"}, rd, exp_stat);
  endtask

  // ---------------------------------------------------------------
  // vector table
  // ---------------------------------------------------------------
  typedef struct {
    logic              is_wr;
    logic [1:0]        addr;
    logic [31:0]       wdata;
    logic              rdy;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_port;
    logic [31:0]       exp_stat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic is_wr, input logic [1:0] addr, input logic [31:0] wdata,
                              input logic rdy, input logic exp_valid,
                              input logic [DATA_W-1:0] exp_port, input logic [31:0] exp_stat);
    vec_t v;
    v.is_wr     = is_wr;
    v.addr      = addr;
    v.wdata     = wdata;
    v.rdy       = rdy;
    v.exp_valid = exp_valid;
    v.exp_port  = exp_port;
    v.exp_stat  = exp_stat;
    return v;
  endfunction

  initial begin
    logic [31:0]       rd;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] exp_irq_bits;

    // ---- table contents ----
    // single key, then consume it
    vecs.push_back(mk(1'b1, 2'd0, 32'h1C, 1'b0, 1'b1, 8'h1C, 32'h0000_0001));
    vecs.push_back(mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b0, 8'h00, ST_EMPTY));
    // push with out_ready high while empty: push taken, nothing popped
    vecs.push_back(mk(1'b1, 2'd0, 32'h33, 1'b1, 1'b1, 8'h33, 32'h0000_0001));
    vecs.push_back(mk(1'b0, 2'd0, 32'h00, 1'b1, 1'b0, 8'h00, ST_EMPTY));
    // fill 0x04..0x0B
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1'b1, 2'd0, 32'(4 + k), 1'b0, 1'b1, 8'h04,
                        32'(k + 1) | ((k == 7) ? ST_FULL : 32'h0)));
    // push into full FIFO: dropped, overflow set
    vecs.push_back(mk(1'b1, 2'd0, 32'h0C, 1'b0, 1'b1, 8'h04, ST_OVF | ST_FULL | 32'd8));
    // drain in order
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b0, 2'd0, 32'h0, 1'b1, (i < 8), (i < 8) ? 8'(4 + i) : 8'h00,
                        32'(8 - i) | ST_OVF | ((i == 8) ? ST_EMPTY : 32'h0)));
    // clear overflow
    vecs.push_back(mk(1'b1, 2'd1, 32'h2, 1'b0, 1'b0, 8'h00, ST_EMPTY));
    // reserved address write is ignored
    vecs.push_back(mk(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, ST_EMPTY));

    // ---- reset ----
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    out_ready  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.readdata_idle", readdata, 32'h0);
    check("rst.irq", {31'd0, irq}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("rst", 1'b0, 8'h00, ST_EMPTY);

    // ---- table-driven vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].rdy);
      else               idle(vecs[i].rdy);
      check_state($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_port, vecs[i].exp_stat);
    end
    bus_read(2'd3, rd);
    check("reserved.read", rd, 32'h0);

    // ---- push+pop while full, 3 fill/drain rounds for pointer wrap ----
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 8; k++) begin
        key = 8'h04 + 8'(c * 16) + 8'(k);
        bus_write(2'd0, {24'd0, key}, 1'b0);
        exp_q.push_back(key);
      end
      check_state($sformatf("wrap%0d.full", c), 1'b1, exp_q[0], ST_FULL | 32'd8);
      key = 8'h2A + 8'(c);
      bus_write(2'd0, {24'd0, key}, 1'b1);
      void'(exp_q.pop_front());
      exp_q.push_back(key);
      check_state($sformatf("wrap%0d.pushpop", c), 1'b1, exp_q[0], ST_FULL | 32'd8);
      for (int i = 0; i < 8; i++) begin
        check($sformatf("wrap%0d.drain%0d", c, i), {24'd0, out_port}, {24'd0, exp_q[0]});
        idle(1'b1);
        void'(exp_q.pop_front());
      end
      check_state($sformatf("wrap%0d.empty", c), 1'b0, 8'h00, ST_EMPTY);
    end

    // ---- flush with pop request on same edge, overflow cleared too ----
    for (int k = 0; k < 8; k++) bus_write(2'd0, 32'(8'h60 + k), 1'b0);
    bus_write(2'd0, 32'h70, 1'b0);
    repeat (5) idle(1'b1);
    check_state("flush.pre", 1'b1, 8'h65, ST_OVF | 32'd3);
    bus_write(2'd1, 32'h3, 1'b1);
    check_state("flush.post", 1'b0, 8'h00, ST_EMPTY);
    bus_write(2'd0, 32'h50, 1'b0);
    check_state("flush.push_after", 1'b1, 8'h50, 32'd1);
    idle(1'b1);
    check_state("flush.drained", 1'b0, 8'h00, ST_EMPTY);

    // ---- IRQ level behaviour ----
    bus_read(2'd2, rd);
    check("irq.cfg_reset", rd, IRQ_BUILD ? 32'h0000_0001 : 32'h0);
    bus_write(2'd2, 32'h8000_0003, 1'b0);
    bus_read(2'd2, rd);
    check("irq.cfg_readback", rd, IRQ_BUILD ? 32'h8000_0003 : 32'h0);
    exp_irq_bits = {5'd0, IRQ_BUILD ? 3'b100 : 3'b000};
    for (int k = 0; k < 3; k++) begin
      bus_write(2'd0, 32'(8'hA0 + k), 1'b0);
      check($sformatf("irq.push%0d", k), {31'd0, irq}, {31'd0, exp_irq_bits[k]});
    end
    idle(1'b1);
    check("irq.after_pop", {31'd0, irq}, 32'h0);
    repeat (2) idle(1'b1);
    check_state("irq.drained", 1'b0, 8'h00, ST_EMPTY);

    // ---- asynchronous reset mid-drain ----
    for (int k = 0; k < 6; k++) bus_write(2'd0, 32'(8'h80 + k), 1'b0);
    idle(1'b1);
    check_state("areset.pre", 1'b1, 8'h81, 32'd5);
    check("areset.irq_pre", {31'd0, irq}, {31'd0, IRQ_BUILD});
    out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check("areset.valid", {31'd0, out_valid}, 32'h0);
    check("areset.port", {24'd0, out_port}, 32'h0);
    check("areset.irq", {31'd0, irq}, 32'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk);
    #1;
    check_state("areset.post", 1'b0, 8'h00, ST_EMPTY);

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
